// File: rtl/scb_cnt_if.sv
// -----------------------------------------------------------------------------
// scb_cnt_if
// Bundles the issue-stage side of the counting register scoreboard.
//   chk_op_ready_val/idx -> chk_op_ready : dependency check ports
//   clr_op_ready_val/idx -> clr_op_ready_ok : issue ports (rd goes pending)
//   set_op_ready_val/idx : writeback ports (one pending write retires)
//   flush, err_clr       : pipeline kill and sticky-error clear
//   busy_any, err_ovf, err_udf : status outputs
// The master modport is the issue logic, the slave modport is the scoreboard.
// -----------------------------------------------------------------------------
interface scb_cnt_if #(
  parameter int IDX_W      = 5,
  parameter int N_CHK_PORT = 3,
  parameter int N_CLR_PORT = 1,
  parameter int N_SET_PORT = 2
);
  logic [N_CHK_PORT-1:0]            chk_op_ready_val;
  logic [N_CHK_PORT-1:0][IDX_W-1:0] chk_op_ready_idx;
  logic [N_CHK_PORT-1:0]            chk_op_ready;
  logic [N_CLR_PORT-1:0]            clr_op_ready_val;
  logic [N_CLR_PORT-1:0][IDX_W-1:0] clr_op_ready_idx;
  logic [N_CLR_PORT-1:0]            clr_op_ready_ok;
  logic [N_SET_PORT-1:0]            set_op_ready_val;
  logic [N_SET_PORT-1:0][IDX_W-1:0] set_op_ready_idx;
  logic                             flush;
  logic                             busy_any;
  logic                             err_ovf;
  logic                             err_udf;
  logic                             err_clr;

  modport master (
    output chk_op_ready_val, chk_op_ready_idx,
    output clr_op_ready_val, clr_op_ready_idx,
    output set_op_ready_val, set_op_ready_idx,
    output flush, err_clr,
    input  chk_op_ready, clr_op_ready_ok, busy_any, err_ovf, err_udf
  );

  modport slave (
    input  chk_op_ready_val, chk_op_ready_idx,
    input  clr_op_ready_val, clr_op_ready_idx,
    input  set_op_ready_val, set_op_ready_idx,
    input  flush, err_clr,
    output chk_op_ready, clr_op_ready_ok, busy_any, err_ovf, err_udf
  );
endinterface

// File: rtl/scb_cnt.sv
// -----------------------------------------------------------------------------
// scb_cnt
// Counting register scoreboard. Every architectural register keeps a count of
// in-flight writes, so several outstanding writers to one rd are tracked.
// Ports:
//   clk    : clock
//   arst_n : asynchronous active-low reset
//   bus    : scb_cnt_if slave (check, issue, writeback, flush, status)
// -----------------------------------------------------------------------------
module scb_cnt #(
  parameter int N_REG      = 32,
  parameter int IDX_W      = $clog2(N_REG),
  parameter int N_CHK_PORT = 3,
  parameter int N_CLR_PORT = 1,
  parameter int N_SET_PORT = 2,
  parameter int CNT_W      = 2,
  parameter int BYPASS     = 0,
  parameter int R0_ZERO    = 1
) (
  input logic      clk,
  input logic      arst_n,
  scb_cnt_if.slave bus
);
  // Two extra bits keep cnt + inc - dec free of wrap; the top bit is the sign.
  localparam int               SUM_W   = CNT_W + 2;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0]      r_cnt [N_REG];
  logic                  r_errOvf;
  logic                  r_errUdf;

  logic [SUM_W-1:0]      w_inc [N_REG];
  logic [SUM_W-1:0]      w_dec [N_REG];
  logic [SUM_W-1:0]      w_sum [N_REG];
  logic [CNT_W-1:0]      w_cntNext [N_REG];
  logic                  w_ovfHit;
  logic                  w_udfHit;
  logic [N_CHK_PORT-1:0] w_chkRdy;
  logic [N_CLR_PORT-1:0] w_clrOk;
  logic [SUM_W-1:0]      w_hits;
  logic                  w_busy;

  // Count issue and writeback hits per register. Register 0 never counts when
  // it is hardwired, and indices beyond N_REG simply match no register.
  always_comb begin
    for (int r = 0; r < N_REG; r++) begin
      w_inc[r] = '0;
      w_dec[r] = '0;
      if (!(R0_ZERO != 0 && r == 0)) begin
        for (int p = 0; p < N_CLR_PORT; p++)
          if (bus.clr_op_ready_val[p] && bus.clr_op_ready_idx[p] == IDX_W'(r))
            w_inc[r] = w_inc[r] + SUM_W'(1);
        for (int p = 0; p < N_SET_PORT; p++)
          if (bus.set_op_ready_val[p] && bus.set_op_ready_idx[p] == IDX_W'(r))
            w_dec[r] = w_dec[r] + SUM_W'(1);
      end
    end
  end

  // Next counter values with saturation at both ends. A flush wipes every
  // counter and swallows any error the dropped clr/set would have raised.
  always_comb begin
    w_ovfHit = 1'b0;
    w_udfHit = 1'b0;
    for (int r = 0; r < N_REG; r++) begin
      w_sum[r]     = SUM_W'(r_cnt[r]) + w_inc[r] - w_dec[r];
      w_cntNext[r] = r_cnt[r];
      if (bus.flush) begin
        w_cntNext[r] = '0;
      end else if (w_sum[r][SUM_W-1]) begin
        w_cntNext[r] = '0;
        w_udfHit     = 1'b1;
      end else if (w_sum[r] > CNT_MAX) begin
        w_cntNext[r] = CNT_MAX[CNT_W-1:0];
        w_ovfHit     = 1'b1;
      end else begin
        w_cntNext[r] = w_sum[r][CNT_W-1:0];
      end
    end
  end

  // Dependency check. With bypass, a register whose remaining writes all
  // retire this cycle already counts as ready.
  always_comb begin
    for (int p = 0; p < N_CHK_PORT; p++) begin
      w_chkRdy[p] = 1'b0;
      if (R0_ZERO != 0 && bus.chk_op_ready_idx[p] == '0) begin
        w_chkRdy[p] = bus.chk_op_ready_val[p];
      end else begin
        for (int r = 0; r < N_REG; r++)
          if (bus.chk_op_ready_idx[p] == IDX_W'(r)) begin
            if (r_cnt[r] == '0)
              w_chkRdy[p] = bus.chk_op_ready_val[p];
            else if (BYPASS != 0 && SUM_W'(r_cnt[r]) == w_dec[r])
              w_chkRdy[p] = bus.chk_op_ready_val[p];
          end
      end
    end
  end

  // Issue headroom: port p sees its own hit plus those of lower-numbered ports
  // on the same rd, regardless of valid, so issue logic can gate on it.
  always_comb begin
    w_hits = '0;
    for (int p = 0; p < N_CLR_PORT; p++) begin
      w_clrOk[p] = 1'b1;
      w_hits     = '0;
      if (!(R0_ZERO != 0 && bus.clr_op_ready_idx[p] == '0)) begin
        for (int q = 0; q <= p; q++)
          if (bus.clr_op_ready_idx[q] == bus.clr_op_ready_idx[p])
            w_hits = w_hits + SUM_W'(1);
        for (int r = 0; r < N_REG; r++)
          if (bus.clr_op_ready_idx[p] == IDX_W'(r))
            w_clrOk[p] = (SUM_W'(r_cnt[r]) + w_hits) <= CNT_MAX;
      end
    end
  end

  // Busy summary from the registered counters only.
  always_comb begin
    w_busy = 1'b0;
    for (int r = 0; r < N_REG; r++)
      if (r_cnt[r] != '0)
        w_busy = 1'b1;
  end

  // Counter and sticky error state. err_clr wins over a same-cycle error.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int r = 0; r < N_REG; r++)
        r_cnt[r] <= '0;
      r_errOvf <= 1'b0;
      r_errUdf <= 1'b0;
    end else begin
      for (int r = 0; r < N_REG; r++)
        r_cnt[r] <= w_cntNext[r];
      if (bus.err_clr) begin
        r_errOvf <= 1'b0;
        r_errUdf <= 1'b0;
      end else begin
        if (w_ovfHit)
          r_errOvf <= 1'b1;
        if (w_udfHit)
          r_errUdf <= 1'b1;
      end
    end
  end

  assign bus.chk_op_ready    = w_chkRdy;
  assign bus.clr_op_ready_ok = w_clrOk;
  assign bus.busy_any        = w_busy;
  assign bus.err_ovf         = r_errOvf;
  assign bus.err_udf         = r_errUdf;
endmodule
